// File: rtl/cpu_pkg.sv
// Shared types and widths for the accumulator CPU datapath.
// Optional carry flag is enabled by defining CPU_CARRY_EN.
package cpu_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 5;
    localparam int PHASE_W = 3;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

endpackage

// File: rtl/cpu_alu.sv
// Accumulator ALU keyed on the IR opcode.
// Carry is the ADD carry-out and is 0 for every other opcode.
module cpu_alu
    import cpu_pkg::*;
(
    input  opcode_t             opcode,
    input  logic [DATA_W-1:0]   ac,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   result,
    output logic                carry
);

    // Opcode decode; pass-through opcodes keep AC unchanged.
    always_comb begin
        result = ac;
        carry  = 1'b0;
        case (opcode)
            OP_ADD:  {carry, result} = {1'b0, ac} + {1'b0, mem_rdata};
            OP_AND:  result = ac & mem_rdata;
            OP_XOR:  result = ac ^ mem_rdata;
            OP_LDA:  result = mem_rdata;
            default: result = ac;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: phase counter, PC, IR, AC and halt flag.
// Define CPU_CARRY_EN to add the registered ADD carry output.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                sel,
    input  logic                rd,
    input  logic                ld_ir,
    input  logic                inc_pc,
    input  logic                ld_pc,
    input  logic                data_e,
    input  logic                ld_ac,
    input  logic                wr,
    input  logic                halt,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [PHASE_W-1:0]  phase,
    output logic [2:0]          opcode,
    output logic                zero,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                halted
`ifdef CPU_CARRY_EN
    ,
    output logic                carry
`endif
);

    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] ac;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cy;
    opcode_t           op;
    logic              run;

    assign op        = opcode_t'(ir[DATA_W-1:ADDR_W]);
    assign opcode    = ir[DATA_W-1:ADDR_W];
    assign zero      = (ac == '0);
    assign mem_addr  = sel ? pc : ir[ADDR_W-1:0];
    assign mem_rd    = rd;
    assign mem_wr    = wr;
    assign mem_wdata = data_e ? ac : '0;
    assign run       = !halted && !halt;

    cpu_alu u_alu (
        .opcode    (op),
        .ac        (ac),
        .mem_rdata (mem_rdata),
        .result    (alu_res),
        .carry     (alu_cy)
    );

    // Architectural registers; a halt edge freezes everything until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= '0;
            pc     <= '0;
            ir     <= '0;
            ac     <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (halt) begin
                halted <= 1'b1;
            end else begin
                phase <= phase + PHASE_W'(1);
                if (ld_ir) ir <= mem_rdata;
                if (ld_ac) ac <= alu_res;
                if (ld_pc) pc <= ir[ADDR_W-1:0];
                else if (inc_pc) pc <= pc + ADDR_W'(1);
            end
        end
    end

`ifdef CPU_CARRY_EN
    // Carry flag captures the ADD carry-out when AC is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
        end else if (run && ld_ac && op == OP_ADD) begin
            carry <= alu_cy;
        end
    end
`else
    logic unused_cy;
    assign unused_cy = alu_cy ^ run;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath against a behavioural model.
// Build with CPU_CARRY_EN defined to also check the carry output.
module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       rst, sel, rd, ld_ir, inc_pc, ld_pc;
    logic       data_e, ld_ac, wr, halt;
    logic [7:0] mem_rdata;
    logic [2:0] phase, opcode;
    logic       zero, mem_rd, mem_wr, halted;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
`ifdef CPU_CARRY_EN
    logic       carry;
`endif

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model state
    int m_phase, m_pc, m_ir, m_ac, m_halted, m_cy;

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .rd        (rd),
        .ld_ir     (ld_ir),
        .inc_pc    (inc_pc),
        .ld_pc     (ld_pc),
        .data_e    (data_e),
        .ld_ac     (ld_ac),
        .wr        (wr),
        .halt      (halt),
        .mem_rdata (mem_rdata),
        .phase     (phase),
        .opcode    (opcode),
        .zero      (zero),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .halted    (halted)
`ifdef CPU_CARRY_EN
        ,
        .carry     (carry)
`endif
    );

    task automatic idle();
        rst = 0; sel = 0; rd = 0; ld_ir = 0; inc_pc = 0; ld_pc = 0;
        data_e = 0; ld_ac = 0; wr = 0; halt = 0; mem_rdata = 8'h00;
    endtask

    // Clock edge plus model update from the instruction-level rules.
    task automatic tick();
        int op, res, npc, cy;
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_pc = 0; m_ir = 0; m_ac = 0;
            m_halted = 0; m_cy = 0;
        end else if (m_halted == 0) begin
            if (halt) begin
                m_halted = 1;
            end else begin
                op = m_ir / 32;
                cy = 0;
                if (op == 2) begin
                    res = m_ac + int'(mem_rdata);
                    cy = res / 256;
                    res = res % 256;
                end else if (op == 3) res = m_ac & int'(mem_rdata);
                else if (op == 4) res = m_ac ^ int'(mem_rdata);
                else if (op == 5) res = int'(mem_rdata);
                else res = m_ac;
                npc = m_pc;
                if (ld_pc) npc = m_ir % 32;
                else if (inc_pc) npc = (m_pc + 1) % 32;
                m_phase = (m_phase + 1) % 8;
                if (ld_ac) m_ac = res;
                if (ld_ac && op == 2) m_cy = cy;
                if (ld_ir) m_ir = int'(mem_rdata);
                m_pc = npc;
            end
        end
        #1;
    endtask

    // Reads PC, IR[4:0] and AC through the memory-side outputs.
    task automatic peek(output int pc, output int irl, output int ac);
        sel = 1; data_e = 1; #1;
        pc = int'(mem_addr); ac = int'(mem_wdata);
        sel = 0; #1;
        irl = int'(mem_addr);
        data_e = 0; #1;
    endtask

    task automatic load_op(input logic [7:0] ir_v, input logic [7:0] d);
        idle(); ld_ir = 1; mem_rdata = ir_v; tick();
        idle(); ld_ac = 1; mem_rdata = d; tick();
        idle();
    endtask

    task automatic test_reset();
        int pc, irl, ac;
        idle(); rst = 1; tick(); idle();
        peek(pc, irl, ac);
        n_chk++;
        if (phase !== 3'd0 || opcode !== 3'd0 || zero !== 1'b1
            || halted !== 1'b0 || pc != 0 || ac != 0 || irl != 0) begin
            n_fail++;
            $display("FAIL reset: ph=%0d op=%0d z=%b h=%b pc=%0d ac=%0d ir=%0d want 0 0 1 0 0 0 0",
                     phase, opcode, zero, halted, pc, ac, irl);
        end
`ifdef CPU_CARRY_EN
        n_chk++;
        if (carry !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_carry: got %b want 0", carry);
        end
`endif
    endtask

    task automatic test_ld_ir();
        idle(); ld_ir = 1; mem_rdata = 8'h4A; tick(); idle();
        sel = 0; #1;
        n_chk++;
        if (opcode !== 3'b010) begin
            n_fail++;
            $display("FAIL ld_ir_opcode: got %0d want 2", opcode);
        end
        n_chk++;
        if (mem_addr !== 5'h0A) begin
            n_fail++;
            $display("FAIL ld_ir_addr: got %h want 0a", mem_addr);
        end
    endtask

    task automatic test_alu_add();
        int pc, irl, ac;
        load_op(8'hA0, 8'hF0);
        load_op(8'h4A, 8'h20);
        peek(pc, irl, ac);
        n_chk++;
        if (ac != 8'h10 || zero !== 1'b0 || ac != m_ac) begin
            n_fail++;
            $display("FAIL add: ac=%h z=%b want 10 0", ac, zero);
        end
`ifdef CPU_CARRY_EN
        n_chk++;
        if (carry !== 1'b1) begin
            n_fail++;
            $display("FAIL add_carry: got %b want 1", carry);
        end
`endif
    endtask

    task automatic test_pc();
        int pc, irl, ac;
        idle(); ld_ir = 1; mem_rdata = 8'h1F; tick();
        idle(); ld_pc = 1; tick(); idle();
        peek(pc, irl, ac);
        n_chk++;
        if (pc != 31) begin
            n_fail++;
            $display("FAIL pc_load: got %0d want 31", pc);
        end
        inc_pc = 1; tick(); idle();
        peek(pc, irl, ac);
        n_chk++;
        if (pc != 0) begin
            n_fail++;
            $display("FAIL pc_wrap: got %0d want 0", pc);
        end
        ld_ir = 1; mem_rdata = 8'h07; tick();
        idle(); ld_pc = 1; inc_pc = 1; tick(); idle();
        peek(pc, irl, ac);
        n_chk++;
        if (pc != 7) begin
            n_fail++;
            $display("FAIL pc_priority: got %0d want 7", pc);
        end
    endtask

    task automatic test_halt();
        int pc, irl, ac;
        idle(); rst = 1; tick(); idle();
        load_op(8'hA0, 8'h3C);
        idle(); rst = 1; tick(); idle();
        inc_pc = 1; tick(); tick(); idle();
        n_chk++;
        if (phase !== 3'd2) begin
            n_fail++;
            $display("FAIL halt_setup: phase=%0d want 2", phase);
        end
        halt = 1; inc_pc = 1; ld_ac = 1; mem_rdata = 8'h55; tick(); idle();
        n_chk++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_flag: got %b want 1", halted);
        end
        for (int i = 0; i < 10; i++) begin
            ld_ir = 1'($urandom); ld_ac = 1'($urandom);
            inc_pc = 1'($urandom); ld_pc = 1'($urandom);
            rd = 1'($urandom); wr = 1'($urandom);
            mem_rdata = 8'($urandom);
            tick();
            n_chk++;
            if (mem_rd !== rd || mem_wr !== wr) begin
                n_fail++;
                $display("FAIL halt_strobes: rd=%b wr=%b want %b %b",
                         mem_rd, mem_wr, rd, wr);
            end
            peek(pc, irl, ac);
            n_chk++;
            if (phase !== 3'd2 || pc != 2 || ac != 0 || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_frozen: ph=%0d pc=%0d ac=%0d h=%b want 2 2 0 1",
                         phase, pc, ac, halted);
            end
        end
        idle(); rst = 1; halt = 1; ld_ac = 1; tick(); idle();
        peek(pc, irl, ac);
        n_chk++;
        if (phase !== 3'd0 || pc != 0 || ac != 0 || halted !== 1'b0
            || zero !== 1'b1 || opcode !== 3'd0) begin
            n_fail++;
            $display("FAIL halt_reset: ph=%0d pc=%0d ac=%0d h=%b",
                     phase, pc, ac, halted);
        end
    endtask

    task automatic test_wrap_wdata();
        int pc, irl, ac;
        idle(); rst = 1; tick(); idle();
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_chk++;
            if (int'(phase) != i % 8) begin
                n_fail++;
                $display("FAIL phase_wrap: step %0d got %0d want %0d",
                         i, phase, i % 8);
            end
        end
        load_op(8'hA0, 8'h5C);
        data_e = 1; #1;
        n_chk++;
        if (mem_wdata !== 8'h5C) begin
            n_fail++;
            $display("FAIL wdata_on: got %h want 5c", mem_wdata);
        end
        data_e = 0; #1;
        n_chk++;
        if (mem_wdata !== 8'h00) begin
            n_fail++;
            $display("FAIL wdata_off: got %h want 00", mem_wdata);
        end
    endtask

    task automatic test_random();
        int pc, irl, ac;
        idle(); rst = 1; tick(); idle();
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            ld_ir = 1'($urandom); ld_ac = 1'($urandom);
            inc_pc = 1'($urandom); ld_pc = ($urandom_range(0, 3) == 0);
            mem_rdata = 8'($urandom);
            tick();
            idle();
            peek(pc, irl, ac);
            n_chk++;
            if (int'(phase) != m_phase || int'(opcode) != m_ir / 32
                || pc != m_pc || irl != m_ir % 32 || ac != m_ac
                || zero !== (m_ac == 0) || halted !== 1'b0) begin
                n_fail++;
                $display("FAIL random[%0d]: ph=%0d op=%0d pc=%0d ac=%0d z=%b want %0d %0d %0d %0d",
                         i, phase, opcode, pc, ac, zero,
                         m_phase, m_ir / 32, m_pc, m_ac);
            end
`ifdef CPU_CARRY_EN
            n_chk++;
            if (int'(carry) != m_cy) begin
                n_fail++;
                $display("FAIL random_carry[%0d]: got %b want %0d", i, carry, m_cy);
            end
`endif
        end
    endtask

    initial begin
        idle();
        m_phase = 0; m_pc = 0; m_ir = 0; m_ac = 0; m_halted = 0; m_cy = 0;
        #2;
        test_reset();
        test_ld_ir();
        test_alu_add();
        test_pc();
        test_halt();
        test_wrap_wdata();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
